parity_check_arbiter: RTL and testbench
=======================================

Name: parity_check_arbiter

Overview:
Shares one even-parity check datapath between NUM_REQ requesters. Each requester offers a byte plus its received parity bit on a valid/ready handshake. A round-robin arbiter grants one requester per cycle. A single-entry output register then returns the byte, the requester ID and the error flag on a downstream valid/ready interface. The block sits between the byte-link receivers and the error-reporting / retry logic.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
ID_W, $clog2(NUM_REQ), width of the requester ID.
CNT_W, 8, width of each per-requester error counter (optional feature only).

Ports:
clk  input  1  clock; all logic is rising-edge.
rst_n  input  1  synchronous, active-low reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_data  input  NUM_REQ*8  byte of requester i at bits [8i+7:8i].
req_parity  input  NUM_REQ  received parity bit of requester i.
req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
res_valid  output  1  result valid.
res_ready  input  1  downstream accept.
res_id  output  ID_W  index of the granted requester.
res_data  output  8  checked byte, passed through unchanged.
res_error  output  1  1 when (XOR of res_data) != received parity bit.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous, active-low, on rst_n.
- Reset values: res_valid=0, res_id=0, res_data=0, res_error=0, rr_ptr=0; req_ready is all zeros while rst_n=0.
- Slot free condition: slot_free = !res_valid || res_ready.
- Grant rule (combinational):
  - When slot_free is high, req_ready is one-hot on the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - When slot_free is low, or no request is valid, req_ready is 0.
  - req_ready never depends on the requester's own req_valid beyond this search.
- On a transfer from requester g (registered):
  - res_valid<=1, res_id<=g, res_data<=req_data[g], res_error<=(^req_data[g]) != req_parity[g].
  - rr_ptr<=(g+1) mod NUM_REQ; wrap-around from NUM_REQ-1 goes to 0.
- On res_valid && res_ready with no new grant: res_valid<=0. Other result fields hold their last value.
- Simultaneous drain and grant: when res_ready=1 and a grant happens in the same cycle, the new result replaces the old one. This gives full throughput of 1 result per cycle with no bubble.
- Latency: exactly 1 cycle from the transfer edge to res_valid.
- Backpressure: while res_valid=1 and res_ready=0, the result fields are stable, req_ready=0 and rr_ptr is frozen.
- Fairness: a continuously asserted requester is granted at least once every NUM_REQ grants.
- Reset mid-operation: a pending result is discarded, rr_ptr returns to 0, and no transfer is completed on a reset cycle.
- Arbiter states: IDLE (res_valid=0) and HOLD (res_valid=1).
  - IDLE->HOLD on a grant.
  - HOLD->IDLE on drain with no grant.
  - HOLD->HOLD on a stall, or on drain with a grant.

Optional Feature:
Macro: PARITY_ERR_CNT_EN.
- Defined:
  - Adds input err_clr (1) and output err_cnt (NUM_REQ*CNT_W).
  - counter[g] increments on each transfer from requester g whose computed error is 1.
  - Counters saturate at 2^CNT_W-1.
  - err_clr=1 zeroes all counters and takes priority over an increment in the same cycle.
  - All counters reset to 0.
- Not defined: no err_clr or err_cnt ports and no counter logic. All other behaviour is identical.

Decomposition:
- Package parity_pkg holds the localparam BYTE_W=8 and the function even_parity(byte) returning the XOR reduction.
- One natural sub-module, rr_arbiter: a generic NUM_REQ round-robin grant from rr_ptr and the request vector, with an enable input.
- Parity compute is inlined through the package function.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0 and res_valid=0. After release, the first grant goes to requester 0.
- Single requester, good parity: req 2 sends data=0x96, parity=0, res_ready=1 -> next cycle res_valid=1, res_id=2, res_data=0x96, res_error=0.
- Single requester, bad parity: req 1 sends data=0x01, parity=0 -> res_id=1, res_error=1.
- Round-robin, all 4 valid continuously, res_ready=1 -> grant order 0,1,2,3,0, one result per cycle with no bubbles.
- Backpressure: res_ready=0 for 3 cycles with result 0x5A pending -> res fields stable, req_ready=0, rr_ptr unchanged. On release, the next requester is granted in the drain cycle.
- With PARITY_ERR_CNT_EN and CNT_W=2: send 5 bad-parity bytes on req 3 -> err_cnt[3]=3 (saturated). Then err_clr for 1 cycle -> 0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared constants and the parity helper for the parity check arbiter.
package parity_pkg;

  localparam int unsigned BYTE_W = 8;

  // Even parity of a byte: the XOR reduction of its bits.
  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin grant: first set request at or after ptr, modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt_c,
  output logic [ID_W-1:0] gnt_id_c,
  output logic            gnt_any_c
);

  logic [ID_W-1:0] idx;

  // Scan req starting at ptr and wrapping; the first hit wins.
  always_comb begin
    gnt_c     = '0;
    gnt_id_c  = '0;
    gnt_any_c = 1'b0;
    idx       = '0;
    if (en) begin
      for (int k = 0; k < int'(N); k++) begin
        idx = ID_W'((32'(ptr) + 32'(k)) % N);
        if (!gnt_any_c && req[idx]) begin
          gnt_any_c  = 1'b1;
          gnt_c[idx] = 1'b1;
          gnt_id_c   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/parity_check_arbiter.sv
// Round-robin shared even-parity checker with a single-entry result register.
// Optional per-requester saturating error counters: define PARITY_ERR_CNT_EN.
module parity_check_arbiter
  import parity_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
`ifdef PARITY_ERR_CNT_EN
  ,
  parameter int unsigned CNT_W   = 8
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_parity,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ID_W-1:0]           res_id,
  output logic [BYTE_W-1:0]         res_data,
  output logic                      res_error
`ifdef PARITY_ERR_CNT_EN
  ,
  input  logic                      err_clr,
  output logic [NUM_REQ*CNT_W-1:0]  err_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     res_id_q, res_id_d;
  logic [BYTE_W-1:0]   res_data_q, res_data_d;
  logic                res_error_q, res_error_d;

  logic                slot_free_c;
  logic                arb_en_c;
  logic [NUM_REQ-1:0]  gnt_c;
  logic [ID_W-1:0]     gnt_id_c;
  logic                gnt_any_c;
  logic [BYTE_W-1:0]   gnt_byte_c;
  logic                gnt_err_c;
  logic [BYTE_W-1:0]   req_bytes [NUM_REQ];

  // Unpack the flat request data bus into one byte per requester.
  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
    assign req_bytes[i] = req_data[i*BYTE_W +: BYTE_W];
  end

  // The slot can take a new result when empty or draining this cycle; reset blocks grants.
  assign slot_free_c = (state_q == IDLE) || res_ready;
  assign arb_en_c    = slot_free_c && rst_n;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .en        (arb_en_c),
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .gnt_c     (gnt_c),
    .gnt_id_c  (gnt_id_c),
    .gnt_any_c (gnt_any_c)
  );

  assign req_ready  = gnt_c;
  assign gnt_byte_c = req_bytes[gnt_id_c];
  assign gnt_err_c  = even_parity(gnt_byte_c) != req_parity[gnt_id_c];

  // Next-state: a grant loads the slot (replacing any drained result), a bare drain empties it.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    res_error_d = res_error_q;
    if (gnt_any_c) begin
      state_d     = HOLD;
      res_id_d    = gnt_id_c;
      res_data_d  = gnt_byte_c;
      res_error_d = gnt_err_c;
      rr_ptr_d    = (gnt_id_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_c + ID_W'(1);
    end else if ((state_q == HOLD) && res_ready) begin
      state_d = IDLE;
    end
  end

  // Arbiter state and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      res_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      res_error_q <= res_error_d;
    end
  end

  assign res_valid = (state_q == HOLD);
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign res_error = res_error_q;

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic [CNT_W-1:0] cnt_d [NUM_REQ];

  // Clear wins over counting; counting saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      for (int i = 0; i < int'(NUM_REQ); i++) cnt_d[i] = '0;
    end else if (gnt_any_c && gnt_err_c && (cnt_q[gnt_id_c] != '1)) begin
      cnt_d[gnt_id_c] = cnt_q[gnt_id_c] + CNT_W'(1);
    end
  end

  // Per-requester error counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REQ); i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_pack_cnt
    assign err_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Directed bench for parity_check_arbiter (NUM_REQ=4); counter checks when PARITY_ERR_CNT_EN is defined.
module tb_parity_check_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
`ifdef PARITY_ERR_CNT_EN
  localparam int unsigned CNT_W   = 2;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_parity;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [ID_W-1:0]      res_id;
  logic [7:0]           res_data;
  logic                 res_error;
`ifdef PARITY_ERR_CNT_EN
  logic                 err_clr;
  logic [NUM_REQ*CNT_W-1:0] err_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  parity_check_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
`ifdef PARITY_ERR_CNT_EN
    ,
    .CNT_W   (CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_parity (req_parity),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_data   (res_data),
    .res_error  (res_error)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_clr    (err_clr),
    .err_cnt    (err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [1:0] id,
                         input logic [7:0] d, input logic e);
    chk({tag, ".valid"}, 32'(res_valid), 32'(v));
    chk({tag, ".id"},    32'(res_id),    32'(id));
    chk({tag, ".data"},  32'(res_data),  32'(d));
    chk({tag, ".error"}, 32'(res_error), 32'(e));
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_data   = '0;
    req_parity = '0;
    res_ready  = 1'b1;
`ifdef PARITY_ERR_CNT_EN
    err_clr    = 1'b0;
`endif

    // Reset held with all requesters valid.
    #2;
    chk("rst.req_ready", 32'(req_ready), 32'h0);
    tick();
    tick();
    chk("rst.req_ready2", 32'(req_ready), 32'h0);
    chk_res("rst", 1'b0, 2'd0, 8'h00, 1'b0);

    // Release: first grant is requester 0.
    rst_n = 1'b1;
    #1;
    chk("first.req_ready", 32'(req_ready), 32'h1);
    tick();
    chk_res("first", 1'b1, 2'd0, 8'h00, 1'b0);
    req_valid = 4'h0;
    tick();
    chk("drain.valid", 32'(res_valid), 32'h0);

    // Single requester, good parity (ptr=1, so req 2 found by wrap search).
    req_valid = 4'b0100;
    req_data[23:16] = 8'h96;
    req_parity = 4'b0000;
    #1;
    chk("good.req_ready", 32'(req_ready), 32'h4);
    tick();
    chk_res("good", 1'b1, 2'd2, 8'h96, 1'b0);

    // Single requester, bad parity, granted while the previous result drains.
    req_valid = 4'b0010;
    req_data[15:8] = 8'h01;
    #1;
    chk("bad.req_ready", 32'(req_ready), 32'h2);
    tick();
    chk_res("bad", 1'b1, 2'd1, 8'h01, 1'b1);
    req_valid = 4'h0;
    tick();
    chk("bad.drain", 32'(res_valid), 32'h0);

    // Reset mid-operation discards a stalled result.
    req_valid = 4'b0100;
    tick();
    res_ready = 1'b0;
    chk("pend.valid", 32'(res_valid), 32'h1);
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("midrst.req_ready", 32'(req_ready), 32'h0);
    tick();
    chk("midrst.valid", 32'(res_valid), 32'h0);
    rst_n = 1'b1;
    res_ready = 1'b1;

    // Round robin with all four valid: 0,1,2,3,0 back to back.
    req_data   = {8'hFF, 8'h07, 8'h22, 8'h11};
    req_parity = 4'b0110;
    #1;
    chk("rr.req_ready0", 32'(req_ready), 32'h1);
    tick();
    chk_res("rr0", 1'b1, 2'd0, 8'h11, 1'b0);
    chk("rr.req_ready1", 32'(req_ready), 32'h2);
    tick();
    chk_res("rr1", 1'b1, 2'd1, 8'h22, 1'b1);
    chk("rr.req_ready2", 32'(req_ready), 32'h4);
    tick();
    chk_res("rr2", 1'b1, 2'd2, 8'h07, 1'b0);
    chk("rr.req_ready3", 32'(req_ready), 32'h8);
    tick();
    chk_res("rr3", 1'b1, 2'd3, 8'hFF, 1'b0);
    chk("rr.req_ready4", 32'(req_ready), 32'h1);
    tick();
    chk_res("rr4", 1'b1, 2'd0, 8'h11, 1'b0);

    // Backpressure with 0x5A pending from requester 1.
    req_data[15:8] = 8'h5A;
    req_parity = 4'b0100;
    tick();
    chk_res("bp.load", 1'b1, 2'd1, 8'h5A, 1'b0);
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp.req_ready", 32'(req_ready), 32'h0);
      tick();
      chk_res("bp.hold", 1'b1, 2'd1, 8'h5A, 1'b0);
    end
    res_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(req_ready), 32'h4);
    tick();
    chk_res("bp.next", 1'b1, 2'd2, 8'h07, 1'b0);
    req_valid = 4'h0;
    tick();
    chk("end.drain", 32'(res_valid), 32'h0);

`ifdef PARITY_ERR_CNT_EN
    // Five bad bytes from requester 3 saturate its 2-bit counter, then clear.
    req_valid = 4'b1000;
    req_data[31:24] = 8'h01;
    req_parity = 4'b0000;
    for (int c = 0; c < 5; c++) tick();
    req_valid = 4'h0;
    chk("cnt.sat", 32'(err_cnt[7:6]), 32'h3);
    chk("cnt.others", 32'(err_cnt[5:0]), 32'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("cnt.clr", 32'(err_cnt), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
